// File: rtl/dcmac_tx_arbiter_if.sv
// dcmac_tx_arbiter_if: N-lane AXI-Stream bundle (lane i occupies slice i of each field)
interface dcmac_tx_arbiter_if #(
    parameter int N      = 1,
    parameter int DATA_W = 1024
);
    localparam int KEEP_W = DATA_W / 8;
    logic [N*DATA_W-1:0] tdata;
    logic [N*KEEP_W-1:0] tkeep;
    logic [N-1:0]        tvalid;
    logic [N-1:0]        tlast;
    logic [N-1:0]        tuser;
    logic [N-1:0]        tready;
    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/dcmac_tx_arbiter.sv
// dcmac_tx_arbiter: packet-granular round-robin arbiter onto one registered AXIS output
module dcmac_tx_arbiter #(
    parameter  int N_SRC  = 4,
    parameter  int DATA_W = 1024,
    localparam int KEEP_W = DATA_W / 8,
    localparam int IW     = $clog2(N_SRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    dcmac_tx_arbiter_if.slave    s,
    dcmac_tx_arbiter_if.master   m,
    output logic [IW-1:0]        grant_idx,
    output logic                 busy,
    output logic [31:0]          pkt_cnt
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t        state;
    logic [IW-1:0] rr_ptr, cand, sel, next_ptr;
    logic [IW:0]   idx;
    logic          found, req, can_load, acc;

    // First valid source at or after rr_ptr; scanning downward leaves the nearest one
    always_comb begin
        found = 1'b0;
        cand  = rr_ptr;
        idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N_SRC)) idx = idx - (IW+1)'(N_SRC);
            if (s.tvalid[idx[IW-1:0]]) begin
                found = 1'b1;
                cand  = idx[IW-1:0];
            end
        end
    end

    assign can_load = ~m.tvalid[0] | m.tready[0];
    assign req      = (state == LOCKED) | found;
    assign sel      = (state == LOCKED) ? grant_idx : cand;
    assign acc      = req & can_load & s.tvalid[sel] & ~rst;
    assign s.tready = (req & can_load & ~rst) ? ({{(N_SRC-1){1'b0}}, 1'b1} << sel) : '0;
    assign next_ptr = (sel == IW'(N_SRC - 1)) ? '0 : sel + 1'b1;
    assign busy     = (state == LOCKED);

    // Grant FSM: lock on a non-final beat, release and rotate priority on tlast
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else if (acc) begin
            grant_idx <= sel;
            if (s.tlast[sel]) begin
                state  <= IDLE;
                rr_ptr <= next_ptr;
            end else begin
                state <= LOCKED;
            end
        end
    end

    // Output stage: load on acceptance, drop valid once the adapter takes the beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m.tvalid <= '0;
            m.tdata  <= '0;
            m.tkeep  <= '0;
            m.tlast  <= '0;
            m.tuser  <= '0;
        end else if (acc) begin
            m.tvalid <= 1'b1;
            m.tdata  <= s.tdata[sel*DATA_W +: DATA_W];
            m.tkeep  <= s.tkeep[sel*KEEP_W +: KEEP_W];
            m.tlast  <= s.tlast[sel];
            m.tuser  <= s.tuser[sel];
        end else if (m.tready[0]) begin
            m.tvalid <= '0;
        end
    end

    // Count packets leaving the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pkt_cnt <= '0;
        else if (m.tvalid[0] & m.tready[0] & m.tlast[0]) pkt_cnt <= pkt_cnt + 1'b1;
    end
endmodule

// File: tb/tb_dcmac_tx_arbiter.sv
// tb_dcmac_tx_arbiter: directed and randomized-backpressure checks of the TX arbiter
module tb_dcmac_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  grant_idx;
    logic        busy;
    logic [31:0] pkt_cnt;

    always #5 clk = ~clk;

    dcmac_tx_arbiter_if #(.N(N), .DATA_W(DW)) src_if ();
    dcmac_tx_arbiter_if #(.N(1), .DATA_W(DW)) out_if ();

    dcmac_tx_arbiter #(.N_SRC(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (src_if),
        .m         (out_if),
        .grant_idx (grant_idx),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt)
    );

    int passed = 0;
    int total  = 0;
    int len[N], bt[N], pk[N], npk[N], exp_pk[N];
    int cur, nb, done_pkts;
    logic [N-1:0] en;
    bit rnd;

    // Beat word carries its own identity so the output can be checked without a model
    function automatic logic [63:0] word(int s, int p, int b, int l);
        return {8'(s), 16'(p), 16'(b), 16'(l), 8'h5a};
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            src_if.tvalid[i]            = en[i] && npk[i] > 0 && !(rnd && $urandom_range(0, 3) == 0);
            src_if.tdata[i*DW +: DW]    = word(i, pk[i], bt[i], len[i]);
            src_if.tkeep[i*KW +: KW]    = 8'(bt[i] * 3 + i + 1);
            src_if.tlast[i]             = (bt[i] == len[i] - 1);
            src_if.tuser[i]             = (bt[i] == len[i] - 1) && pk[i][0];
        end
        out_if.tready[0] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Output beats must form whole, in-order packets per source with fields intact
    task automatic mon();
        logic [63:0] d;
        int s, b, l;
        d = out_if.tdata;
        s = int'(d[57:56]);
        b = int'(d[39:24]);
        l = int'(d[23:8]);
        if (cur < 0) begin
            cur = s;
            nb  = 0;
        end
        chk("stream", 64'(d[63:24]), 64'({8'(cur), 16'(exp_pk[cur]), 16'(nb)}));
        chk("tlast", 64'(out_if.tlast[0]), 64'(b == l - 1));
        chk("tuser", 64'(out_if.tuser[0]), 64'((b == l - 1) && d[40]));
        chk("tkeep", 64'(out_if.tkeep), 64'(8'(b * 3 + s + 1)));
        nb++;
        if (out_if.tlast[0]) begin
            exp_pk[s]++;
            done_pkts++;
            cur = -1;
            nb  = 0;
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = src_if.tvalid & src_if.tready;
        if (out_if.tvalid[0] && out_if.tready[0]) mon();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (bt[i] == len[i] - 1) begin
                    bt[i] = 0;
                    pk[i]++;
                    npk[i]--;
                    if (rnd) len[i] = $urandom_range(1, 6);
                end else begin
                    bt[i]++;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic clear();
        rnd = 0; en = '0; cur = -1; nb = 0; done_pkts = 0;
        for (int i = 0; i < N; i++) begin
            len[i] = 1; bt[i] = 0; pk[i] = 0; npk[i] = 0; exp_pk[i] = 0;
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        clear();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        #1;
    endtask

    initial begin
        // Reset values
        clear();
        drive();
        #2;
        chk("rst_tvalid", 64'(out_if.tvalid), 0);
        chk("rst_tdata", out_if.tdata, 0);
        chk("rst_tready", 64'(src_if.tready), 0);
        chk("rst_grant", 64'(grant_idx), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 0);
        reset_all();

        // Single source, three 4-beat packets, one-cycle latency
        en = 4'b0001; len[0] = 4; npk[0] = 3;
        drive(); #1;
        for (int k = 0; k < 12; k++) begin
            chk("t1_ready", 64'(src_if.tready[0]), 1);
            tick();
            chk("t1_data", out_if.tdata, word(0, k / 4, k % 4, 4));
            chk("t1_grant", 64'(grant_idx), 0);
        end
        tick();
        chk("t1_pkt_cnt", 64'(pkt_cnt), 3);
        chk("t1_idle", 64'(out_if.tvalid), 0);

        // All sources busy with 2-beat packets: strict rotation, no bubbles
        reset_all();
        en = 4'b1111;
        for (int i = 0; i < N; i++) begin len[i] = 2; npk[i] = 2; end
        drive(); #1;
        for (int n = 0; n < 16; n++) begin
            tick();
            chk("t2_order", 64'(out_if.tdata[63:56]), 64'((n / 2) % 4));
            chk("t2_bubble", 64'(out_if.tvalid), 1);
        end
        tick();
        chk("t2_pkt_cnt", 64'(pkt_cnt), 8);

        // Lock holds source 2 off until source 1's tlast
        reset_all();
        en = 4'b0010; len[1] = 5; npk[1] = 1; len[2] = 2; npk[2] = 1;
        drive(); #1;
        tick();
        tick();
        en = 4'b0110;
        drive(); #1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_ready2_blocked", 64'(src_if.tready[2]), 0);
            chk("t3_ready1", 64'(src_if.tready[1]), 1);
            chk("t3_busy", 64'(busy), 1);
            tick();
        end
        chk("t3_last_src", 64'(out_if.tdata[63:56]), 1);
        chk("t3_last", 64'(out_if.tlast), 1);
        chk("t3_released", 64'(busy), 0);
        chk("t3_ready2", 64'(src_if.tready[2]), 1);
        tick();
        chk("t3_next", out_if.tdata, word(2, 0, 0, 2));

        // Single-beat packets from 3 and 0 with rr_ptr=2
        reset_all();
        en = 4'b0010; npk[1] = 1;
        drive(); #1;
        tick();
        en = 4'b1001; npk[0] = 1; npk[3] = 1;
        drive(); #1;
        chk("t5_ready_a", 64'(src_if.tready), 64'(4'b1000));
        chk("t5_busy_a", 64'(busy), 0);
        tick();
        chk("t5_src3", 64'(out_if.tdata[63:56]), 3);
        chk("t5_ready_b", 64'(src_if.tready), 64'(4'b0001));
        chk("t5_busy_b", 64'(busy), 0);
        tick();
        chk("t5_src0", 64'(out_if.tdata[63:56]), 0);
        chk("t5_busy_c", 64'(busy), 0);

        // Random backpressure and valid gaps over 200 random-length packets
        reset_all();
        rnd = 1; en = 4'b1111;
        for (int i = 0; i < N; i++) begin len[i] = $urandom_range(1, 6); npk[i] = 50; end
        drive(); #1;
        for (int c = 0; c < 20000 && done_pkts < 200; c++) tick();
        chk("t4_pkts", 64'(done_pkts), 200);
        chk("t4_pkt_cnt", 64'(pkt_cnt), 200);
        for (int i = 0; i < N; i++) chk("t4_per_src", 64'(exp_pk[i]), 50);

        // Reset during beat 3 of a 6-beat packet
        reset_all();
        en = 4'b0010; npk[1] = 1; len[0] = 6; npk[0] = 1;
        drive(); #1;
        tick();
        en = 4'b0011;
        drive(); #1;
        tick(); tick(); tick();
        chk("t6_pre_cnt", 64'(pkt_cnt), 1);
        chk("t6_pre_busy", 64'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t6_tvalid", 64'(out_if.tvalid), 0);
        chk("t6_pkt_cnt", 64'(pkt_cnt), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_tready", 64'(src_if.tready), 0);
        chk("t6_grant", 64'(grant_idx), 0);
        reset_all();
        en = 4'b0001; len[0] = 2; npk[0] = 1;
        drive(); #1;
        tick();
        chk("t6_new_b0", out_if.tdata, word(0, 0, 0, 2));
        tick();
        chk("t6_new_b1", out_if.tdata, word(0, 0, 1, 2));
        tick();
        chk("t6_new_cnt", 64'(pkt_cnt), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dcmac_tx_arbiter.md
# dcmac_tx_arbiter

Packet-granular round-robin arbiter that shares the single 400G TX AXI-Stream path (1024-bit, 128-byte keep) between N_SRC CASPER stream sources. It sits in front of the 400G AXIS-to-DCMAC TX adapter. It guarantees that packets are never interleaved and that every source with pending data is served fairly. The output is one registered pipeline stage with downstream backpressure.

## Interface
- N_SRC, 4: number of requesting sources (2..8).
- DATA_W, 1024: tdata width; KEEP_W = DATA_W/8.
- clk  in  1  datapath clock (390.625 MHz in 400G builds).
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  N_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- s_tkeep  in  N_SRC*KEEP_W  per-source byte enables, same slicing.
- s_tvalid  in  N_SRC  per-source valid.
- s_tlast  in  N_SRC  per-source end of packet.
- s_tuser  in  N_SRC  per-source error flag.
- s_tready  out  N_SRC  per-source ready.
- m_tdata  out  DATA_W  to TX adapter.
- m_tkeep  out  KEEP_W  to TX adapter.
- m_tvalid  out  1  to TX adapter.
- m_tlast  out  1  to TX adapter.
- m_tuser  out  1  to TX adapter.
- m_tready  in  1  adapter ready.
- grant_idx  out  $clog2(N_SRC)  currently or last granted source.
- busy  out  1  high while in LOCKED.
- pkt_cnt  out  32  packets forwarded (tlast beats accepted at output), wraps.

## Operation
- State machine: IDLE, LOCKED.
- `can_load = ~m_tvalid | m_tready`.
- IDLE:
  - Candidate = first i with s_tvalid[i]=1, searching from rr_ptr upward modulo N_SRC.
  - If a candidate exists, grant_idx takes the candidate's index and `s_tready[candidate] = can_load`.
  - A beat is accepted when s_tvalid & s_tready.
  - Accepted beat with tlast=0: go to LOCKED.
  - Accepted beat with tlast=1: stay in IDLE and set rr_ptr = candidate+1 mod N_SRC.
  - No acceptance (backpressure): no state change, no grant lock. A higher-priority source may still win next cycle.
- LOCKED:
  - Only `s_tready[grant_idx] = can_load`; all other s_tready are 0.
  - An accepted beat with tlast=1 returns to IDLE and sets rr_ptr = grant_idx+1 mod N_SRC.
  - Source valid gaps inside a packet are allowed; the lock is held through them.
- Output register:
  - On acceptance, m_tdata/m_tkeep/m_tlast/m_tuser are loaded from the granted source and m_tvalid is set to 1.
  - Otherwise, if m_tready=1, m_tvalid is cleared.
  - m_* fields hold their value while m_tvalid & ~m_tready.
- pkt_cnt increments on `m_tvalid & m_tready & m_tlast`. It wraps from 0xFFFFFFFF to 0.
- tkeep and tuser are passed through unmodified. No packet-content checks are done here.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, m_tuser=0, s_tready=0 (state IDLE, no candidate), grant_idx=0, rr_ptr=0, busy=0, pkt_cnt=0.
- Latency: source beat accepted in cycle t appears on m_* in cycle t+1.
- s_tready is combinational from s_tvalid, state, m_tvalid and m_tready. There is no combinational path from s_tdata to m_*.
- Throughput: one beat per cycle under continuous m_tready, including back-to-back packets from different sources.
  - The cycle after a tlast acceptance, IDLE arbitrates and accepts with zero bubble.
- Simultaneous requests are resolved purely by rr_ptr order. A source that just finished has lowest priority next.
- m_tready low for any duration:
  - No beat is lost or duplicated.
  - The grant does not change mid-packet.
- Reset asserted mid-packet:
  - Everything is forced to reset values immediately.
  - Any partial packet is truncated; downstream recovery is the adapter's responsibility.
  - After reset release, arbitration restarts from source 0.

## Test plan
- Single source 0, three 4-beat packets, m_tready=1: m_* matches input delayed 1 cycle; pkt_cnt=3; grant_idx=0 throughout.
- All 4 sources continuously valid with 2-beat packets: output source order is 0,1,2,3,0,1,…; no idle cycles; pkt_cnt=8 after 16 output beats.
- Source 1 mid-packet (LOCKED, beat 2 of 5) while source 2 raises valid: s_tready[2] stays 0 until source 1's tlast is accepted; source 2's packet starts the next cycle.
- Random m_tready (50%) over 200 random-length packets from 4 sources: output is a per-packet contiguous, in-order concatenation of source packets; no interleaving; tkeep/tuser preserved.
- Single-beat packets (tlast on first beat) from sources 3 and 0 simultaneously with rr_ptr=2: source 3 goes first, then 0; busy never asserts.
- Assert rst during beat 3 of a 6-beat packet: next cycle m_tvalid=0, pkt_cnt=0, busy=0; after release, a new packet from source 0 is forwarded normally.
